// File: rtl/target_hit_tracker_pkg.sv
// Shared types, default parameters and helpers for the target hit tracker.
// The channel FSM encoding is fixed so that debug taps read the same everywhere.
package target_hit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } ch_state_e;

    localparam int DEF_N_CH    = 2;
    localparam int DEF_N_SENS  = 10;
    localparam int DEF_IDX_W   = 4;
    localparam int DEF_TMR_W   = 32;
    localparam int DEF_DEB_CYC = 4;
    localparam int DEF_SCORE_W = 32;
    localparam int DEF_HIT_PTS = 1;

    // Widest hit vector the score adder can count in one cycle.
    localparam int POP_W = 64;

    function automatic logic [7:0] popcount(input logic [POP_W-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/target_hit_tracker_if.sv
// Processor-side bus of the target hit tracker: arm requests in, channel status
// and score out. The master side is the game processor, the slave side the tracker.
interface target_hit_tracker_if
    import target_hit_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int TMR_W   = DEF_TMR_W,
    parameter int SCORE_W = DEF_SCORE_W
);
    // arm[c] is a single-cycle strobe with no back-pressure: the tracker always
    // accepts it on the clock edge where it is seen high, and arm_target/arm_length
    // for channel c are only meaningful on that edge. Pulses out are one cycle wide.
    logic [N_CH-1:0]       arm;
    logic [N_CH*IDX_W-1:0] arm_target;
    logic [N_CH*TMR_W-1:0] arm_length;
    logic                  clear_score;

    logic [N_CH*IDX_W-1:0] target_out;
    logic [N_CH-1:0]       active;
    logic [N_CH-1:0]       hit_pulse;
    logic [N_CH-1:0]       miss_pulse;
    logic [N_CH-1:0]       err_pulse;
    logic [SCORE_W-1:0]    score;
    logic [N_CH*2-1:0]     state_dbg;

    modport master (
        output arm, arm_target, arm_length, clear_score,
        input  target_out, active, hit_pulse, miss_pulse, err_pulse, score, state_dbg
    );

    modport slave (
        input  arm, arm_target, arm_length, clear_score,
        output target_out, active, hit_pulse, miss_pulse, err_pulse, score, state_dbg
    );

endinterface

// File: rtl/target_hit_tracker_channel.sv
// One target channel: arms a sensor index with a timeout, debounces the sensor
// and reports a single-cycle hit, miss or bad-arm event. All outputs are flops.
module target_channel
    import target_hit_pkg::*;
#(
    parameter int N_SENS  = DEF_N_SENS,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int TMR_W   = DEF_TMR_W,
    parameter int DEB_CYC = DEF_DEB_CYC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_SENS-1:0] photo_array,
    input  logic              arm,
    input  logic [IDX_W-1:0]  arm_target,
    input  logic [TMR_W-1:0]  arm_length,
    output logic [IDX_W-1:0]  target_out,
    output logic              active,
    output logic              hit_pulse,
    output logic              miss_pulse,
    output logic              err_pulse,
    output ch_state_e         state_dbg
);

    localparam int DEB_W = $clog2(DEB_CYC + 1);
    localparam int PAD_W = 2 ** IDX_W;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [IDX_W:0]   SENS_LIM = (IDX_W + 1)'(N_SENS);

    ch_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [IDX_W-1:0] tgt_q, tgt_d;
    logic             active_q, active_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic             err_q, err_d;

    logic [PAD_W-1:0] sens_pad;
    logic             sens;
    logic             in_range;

    // Pad the sensor vector so any latched index selects a defined bit.
    always_comb begin
        sens_pad = '0;
        sens_pad[N_SENS-1:0] = photo_array;
        sens = sens_pad[idx_q];
        in_range = ({1'b0, arm_target} < SENS_LIM);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        deb_d   = deb_q;
        err_d   = arm && !in_range;

        case (state_q)
            ARMED: begin
                if (enable) begin
                    deb_d = sens ? deb_q + DEB_W'(1) : '0;
                    // A completing debounce beats an expiring timer.
                    if (sens && (deb_q == DEB_LAST)) begin
                        state_d = HIT;
                    end else if (tmr_q == '0) begin
                        state_d = MISS;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end else begin
                    deb_d = '0;
                end
            end
            HIT, MISS: state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        if (arm && in_range) begin
            state_d = ARMED;
            idx_d   = arm_target;
            tmr_d   = arm_length;
            deb_d   = '0;
        end

        if (state_d != ARMED) begin
            deb_d = '0;
        end

        active_d = (state_d == ARMED);
        hit_d    = (state_d == HIT);
        miss_d   = (state_d == MISS);
        tgt_d    = (state_d == ARMED) ? idx_d : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tmr_q    <= '0;
            deb_q    <= '0;
            tgt_q    <= '0;
            active_q <= 1'b0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmr_q    <= tmr_d;
            deb_q    <= deb_d;
            tgt_q    <= tgt_d;
            active_q <= active_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
        end
    end

    assign target_out = tgt_q;
    assign active     = active_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign err_pulse  = err_q;
    assign state_dbg  = state_q;

endmodule

// File: rtl/target_hit_tracker.sv
// Multi-channel target manager: N_CH independent target channels sharing a
// saturating score accumulator that counts their hit events.
module target_hit_tracker
    import target_hit_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int N_SENS  = DEF_N_SENS,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int TMR_W   = DEF_TMR_W,
    parameter int DEB_CYC = DEF_DEB_CYC,
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int HIT_PTS = DEF_HIT_PTS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_SENS-1:0]     photo_array,
    target_hit_tracker_if.slave   bus
);

    localparam int SUM_W = ((SCORE_W > 32) ? SCORE_W : 32) + 1;
    localparam logic [SCORE_W-1:0] SCORE_SAT = '1;

    logic [N_CH*IDX_W-1:0] tgt_w;
    logic [N_CH-1:0]       active_w;
    logic [N_CH-1:0]       hit_w;
    logic [N_CH-1:0]       miss_w;
    logic [N_CH-1:0]       err_w;
    logic [N_CH*2-1:0]     state_w;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        ch_state_e st_c;

        target_channel #(
            .N_SENS  (N_SENS),
            .IDX_W   (IDX_W),
            .TMR_W   (TMR_W),
            .DEB_CYC (DEB_CYC)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .enable      (enable),
            .photo_array (photo_array),
            .arm         (bus.arm[c]),
            .arm_target  (bus.arm_target[c*IDX_W +: IDX_W]),
            .arm_length  (bus.arm_length[c*TMR_W +: TMR_W]),
            .target_out  (tgt_w[c*IDX_W +: IDX_W]),
            .active      (active_w[c]),
            .hit_pulse   (hit_w[c]),
            .miss_pulse  (miss_w[c]),
            .err_pulse   (err_w[c]),
            .state_dbg   (st_c)
        );

        assign state_w[c*2 +: 2] = st_c;
    end

    logic [SCORE_W-1:0] score_q, score_d;
    logic [POP_W-1:0]   pop_in;
    logic [SUM_W-1:0]   base_ext, add_ext, sum;

    // Clear happens first so hits landing on the clear cycle still count.
    always_comb begin
        pop_in = '0;
        pop_in[N_CH-1:0] = hit_w;
        base_ext = '0;
        if (!bus.clear_score) begin
            base_ext = SUM_W'(score_q);
        end
        add_ext = SUM_W'(32'(popcount(pop_in)) * 32'(HIT_PTS));
        sum = base_ext + add_ext;
        score_d = (sum > SUM_W'(SCORE_SAT)) ? SCORE_SAT : sum[SCORE_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign bus.target_out = tgt_w;
    assign bus.active     = active_w;
    assign bus.hit_pulse  = hit_w;
    assign bus.miss_pulse = miss_w;
    assign bus.err_pulse  = err_w;
    assign bus.score      = score_q;
    assign bus.state_dbg  = state_w;

endmodule
